// File: rtl/apu_audio_i2s.sv
// Small generic synchronous FIFO with occupancy count; head word is presented combinationally.
// Latency: write visible on rd_dat/count one clk after wr_vld.
// Backpressure: write while full is dropped unless a read fires the same cycle; read while empty is ignored.
module apu_audio_i2s_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_vld,
    input  logic [WIDTH-1:0]      wr_dat,
    input  logic                  rd_rdy,
    output logic [WIDTH-1:0]      rd_dat,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  wr_fire;
    logic                  rd_fire;

    assign empty   = (count == '0);
    assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign rd_fire = rd_rdy && !empty;
    assign wr_fire = wr_vld && (!full || rd_fire);
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// Box-filter decimator + 4-deep FIFO + mono I2S serializer for the APU mixer output.
// Latency: sample enters FIFO 1 clk after its last tick; MSB appears one bit after the next frame load.
// Backpressure: none upstream; full FIFO drops samples (overflow), empty FIFO repeats last word (underflow).
module apu_audio_i2s #(
    parameter int DECIM_LOG2 = 5,
    parameter int BCLK_HALF  = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_clk_en,
    input  logic [15:0] audio_in,
    input  logic        mute,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_data,
    output logic        overflow,
    output logic        underflow
);
    localparam int ACC_W = 16 + DECIM_LOG2;
    localparam int DIV_W = $clog2(BCLK_HALF);

    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_sum;
    logic [DECIM_LOG2-1:0] cnt;
    logic                  dec_vld;
    logic [15:0]           dec_dat;

    logic [2:0]            fifo_count;
    logic [15:0]           fifo_head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_pop;

    logic [DIV_W-1:0]      div;
    logic                  bclk_wrap;
    logic                  bclk_fall;
    logic [4:0]            b;
    logic [4:0]            b_nxt;
    logic                  load;
    logic [15:0]           word;

    assign acc_sum = acc + ACC_W'(audio_in);
    assign dec_vld = cpu_clk_en && (cnt == '1);
    // Offset-binary to two's complement: flip the sign bit.
    assign dec_dat = acc_sum[ACC_W-1 -: 16] ^ 16'h8000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (cpu_clk_en) begin
            acc <= dec_vld ? '0 : acc_sum;
            cnt <= cnt + 1'b1;
        end
    end

    apu_audio_i2s_fifo #(
        .WIDTH      (16),
        .DEPTH_LOG2 (2)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (dec_vld),
        .wr_dat (dec_dat),
        .rd_rdy (fifo_pop),
        .rd_dat (fifo_head),
        .count  (fifo_count)
    );

    assign fifo_empty = (fifo_count == 3'd0);
    assign fifo_full  = (fifo_count == 3'd4);

    assign bclk_wrap = (div == DIV_W'(BCLK_HALF - 1));
    assign bclk_fall = bclk_wrap && i2s_bclk;
    assign b_nxt     = b + 5'd1;
    assign load      = bclk_fall && (b == 5'd31);
    // Mute still drains the FIFO so the stream resumes with fresh samples.
    assign fifo_pop  = load && !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= '0;
            b         <= '0;
            word      <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_data  <= 1'b0;
        end else begin
            div <= bclk_wrap ? '0 : div + 1'b1;
            if (bclk_wrap) begin
                i2s_bclk <= ~i2s_bclk;
            end
            if (bclk_fall) begin
                // One-bit I2S delay: entering slot b_nxt sends bit 15-(b_nxt-1)%16, i.e. old word LSB at slot 0.
                b         <= b_nxt;
                i2s_lrclk <= b_nxt[4];
                i2s_data  <= word[4'd15 - b[3:0]];
                if (load) begin
                    if (mute) begin
                        word <= '0;
                    end else if (!fifo_empty) begin
                        word <= fifo_head;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (dec_vld && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            if (load && !mute && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apu_audio_i2s.sv
// Directed bench for apu_audio_i2s: decimator vector table plus hand-written frame-level sequences.
module tb_apu_audio_i2s;
    localparam int DECIM_LOG2 = 5;
    localparam int BCLK_HALF  = 14;
    localparam int LIM        = 4 * BCLK_HALF + 8;

    logic        clk;
    logic        rst;
    logic        cpu_clk_en;
    logic [15:0] audio_in;
    logic        mute;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_data;
    logic        overflow;
    logic        underflow;

    int          n_vec;
    int          n_err;
    int          n_falls;
    logic [4:0]  tb_b;
    logic        prev_bclk;
    logic        cur_d;
    logic        cur_lr;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } dec_vec_t;

    apu_audio_i2s #(
        .DECIM_LOG2 (DECIM_LOG2),
        .BCLK_HALF  (BCLK_HALF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_clk_en (cpu_clk_en),
        .audio_in   (audio_in),
        .mute       (mute),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_data   (i2s_data),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slot tracker: counts observed bclk falling edges since reset release.
    initial begin
        n_falls   = 0;
        tb_b      = 5'd0;
        prev_bclk = 1'b0;
    end
    always @(negedge clk) begin
        if (rst) begin
            tb_b      = 5'd0;
            prev_bclk = 1'b0;
        end else begin
            if (prev_bclk && !i2s_bclk) begin
                tb_b    = tb_b + 5'd1;
                n_falls = n_falls + 1;
            end
            prev_bclk = i2s_bclk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string what);
        n_vec++;
        n_err++;
        $display("FAIL timeout %s: no bclk falling edge within %0d cycles", what, LIM);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    function automatic logic [31:0] frame_bits(input logic [15:0] w, input logic [15:0] p);
        logic [31:0] r;
        r[0] = p[0];
        for (int s = 1; s < 32; s++) begin
            r[s] = w[15 - ((s - 1) % 16)];
        end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        cpu_clk_en = 1'b0;
        audio_in   = 16'h0000;
        mute       = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_bclk_start(input string tag);
        logic low_ok;
        low_ok = 1'b1;
        for (int i = 1; i < BCLK_HALF; i++) begin
            @(negedge clk);
            if (i2s_bclk !== 1'b0) low_ok = 1'b0;
        end
        check({tag, "_bclk_quiet"}, low_ok, 1);
        @(negedge clk);
        check({tag, "_bclk_rise"}, i2s_bclk, 1);
    endtask

    task automatic push_sample(input logic [15:0] a, input logic [15:0] b,
                               output logic [2:0] pre, output logic [2:0] post);
        pre = '0;
        for (int t = 0; t < 32; t++) begin
            cpu_clk_en = 1'b1;
            audio_in   = t[0] ? b : a;
            if (t == 31) pre = dut.u_fifo.count;
            @(negedge clk);
        end
        cpu_clk_en = 1'b0;
        post = dut.u_fifo.count;
    endtask

    task automatic next_fall();
        int start;
        int n;
        start = n_falls;
        n     = 0;
        while (n_falls == start) begin
            @(negedge clk);
            #1;
            n++;
            if (n > LIM) fail_timeout("slot");
        end
        cur_d  = i2s_data;
        cur_lr = i2s_lrclk;
    endtask

    task automatic capture_frame(input int mute_slot, output logic [31:0] d, output logic [31:0] lr,
                                 output logic [2:0] cnt_ld, output logic uf_ld);
        d = '0;
        lr = '0;
        do next_fall(); while (tb_b != 5'd0);
        d[0]   = cur_d;
        lr[0]  = cur_lr;
        cnt_ld = dut.u_fifo.count;
        uf_ld  = underflow;
        for (int s = 1; s < 32; s++) begin
            next_fall();
            d[s]  = cur_d;
            lr[s] = cur_lr;
            if (s == mute_slot) mute = 1'b1;
        end
    endtask

    initial begin
        dec_vec_t    vecs [8];
        logic [15:0] ovf_words [5];
        logic [15:0] prev;
        logic [31:0] d;
        logic [31:0] lr;
        logic [2:0]  c;
        logic        uf;
        logic [2:0]  pre;
        logic [2:0]  post;

        vecs[0] = '{16'hC000, 16'hC000, 16'h4000};
        vecs[1] = '{16'h0000, 16'h0002, 16'h8001};
        vecs[2] = '{16'h0000, 16'h0001, 16'h8000};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'h7FFF};
        vecs[4] = '{16'h8000, 16'h8000, 16'h0000};
        vecs[5] = '{16'h1234, 16'h1236, 16'h9235};
        vecs[6] = '{16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[7] = '{16'h0003, 16'h0004, 16'h8003};
        ovf_words = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005};

        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        cpu_clk_en = 1'b0;
        audio_in   = 16'h0000;
        mute       = 1'b0;

        // Reset state and first bit-clock edge.
        repeat (3) @(negedge clk);
        check("rst_outputs", {i2s_bclk, i2s_lrclk, i2s_data, overflow, underflow}, 0);
        check("rst_count", dut.u_fifo.count, 0);
        rst = 1'b0;
        check_bclk_start("start");

        // Decimator table: alternate a/b over 32 ticks.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            push_sample(vecs[v].a, vecs[v].b, pre, post);
            check($sformatf("dec%0d_pre", v), pre, 0);
            check($sformatf("dec%0d_post", v), post, 1);
            check($sformatf("dec%0d_head", v), dut.u_fifo.rd_dat, vecs[v].exp);
        end

        // Constant input on the wire, then underflow and repeat.
        do_reset();
        push_sample(16'hC000, 16'hC000, pre, post);
        capture_frame(-1, d, lr, c, uf);
        check("const_ld_count", c, 0);
        check("const_ld_uf", uf, 0);
        check("const_data", d, frame_bits(16'h4000, 16'h0000));
        check("const_lrclk", lr, 32'hFFFF0000);
        capture_frame(-1, d, lr, c, uf);
        check("repeat_uf", uf, 1);
        check("repeat_count", c, 0);
        check("repeat_data", d, frame_bits(16'h4000, 16'h4000));

        // Mute raised in slot 10 with 0x7FFF waiting in the FIFO.
        do_reset();
        push_sample(16'hC000, 16'hC000, pre, post);
        push_sample(16'hFFFF, 16'hFFFF, pre, post);
        check("mute_fill", post, 2);
        capture_frame(10, d, lr, c, uf);
        check("mute_ld1_count", c, 1);
        check("mute_inflight_data", d, frame_bits(16'h4000, 16'h0000));
        capture_frame(-1, d, lr, c, uf);
        check("mute_ld2_count", c, 0);
        check("mute_uf", uf, 0);
        check("mute_data", d, frame_bits(16'h0000, 16'h4000));
        mute = 1'b0;

        // Overflow: five pushes before the first frame load.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_sample(ovf_words[k] ^ 16'h8000, ovf_words[k] ^ 16'h8000, pre, post);
            if (k == 3) begin
                check("ovf_count_at4", post, 4);
                check("ovf_flag_at4", overflow, 0);
            end
        end
        check("ovf_count", post, 4);
        check("ovf_flag", overflow, 1);
        prev = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            capture_frame(-1, d, lr, c, uf);
            check($sformatf("ovf_frame%0d", k), d, frame_bits(ovf_words[k], prev));
            check($sformatf("ovf_ld_count%0d", k), c, 3 - k);
            prev = ovf_words[k];
        end

        // Reset mid-frame (slot 20) with a partial accumulation in flight.
        do next_fall(); while (tb_b != 5'd20);
        check("mid_lrclk", i2s_lrclk, 1);
        check("mid_uf", underflow, 1);
        for (int t = 0; t < 16; t++) begin
            cpu_clk_en = 1'b1;
            audio_in   = 16'hFFFF;
            @(negedge clk);
        end
        cpu_clk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {i2s_bclk, i2s_lrclk, i2s_data, overflow, underflow}, 0);
        check("mid_rst_count", dut.u_fifo.count, 0);
        @(negedge clk);
        rst = 1'b0;
        check_bclk_start("mid");
        push_sample(16'h0000, 16'h0000, pre, post);
        check("mid_acc_post", post, 1);
        check("mid_acc_cleared", dut.u_fifo.rd_dat, 16'h8000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/apu_audio_i2s.md
# apu_audio_i2s

Downstream consumer of the APU mixer output. It box-filters and decimates the 16-bit `audio_out` stream from CPU-clock rate to the audio frame rate, buffers the samples in a 4-entry FIFO, and serializes them as a mono I2S stream (same sample on left and right) for the board audio codec. Overflow and underflow between the decimator and the serializer are reported as sticky flags.

## Interface
Parameters:
- `DECIM_LOG2`, default 5: decimation factor is 2^DECIM_LOG2 `cpu_clk_en` ticks per output sample.
- `BCLK_HALF`, default 14: half-period of `i2s_bclk`, in `clk` cycles. Must be at least 2.
- The defaults target `clk` = 50 MHz, giving about a 55.8 kHz frame rate against a 55.9 kHz decimated rate.

Ports:
- `clk` input 1: system clock, the only clock.
- `rst` input 1: reset, asynchronous, active-high.
- `cpu_clk_en` input 1: CPU-rate enable; `audio_in` is sampled on cycles where this is high.
- `audio_in` input 16: unsigned mixer output (`audio_out` of the APU).
- `mute` input 1: when high, the serializer transmits signed zero.
- `i2s_bclk` output 1: bit clock.
- `i2s_lrclk` output 1: word select; 0 selects left, 1 selects right.
- `i2s_data` output 1: serial data, MSB first.
- `overflow` output 1: sticky; set when a sample is dropped because the FIFO is full.
- `underflow` output 1: sticky; set when a frame starts with the FIFO empty.

## Operation
Decimator:
- Accumulator width is 16+DECIM_LOG2 bits and unsigned. It cannot overflow.
- On each `cpu_clk_en`: `acc += audio_in` and `cnt++`, where `cnt` is DECIM_LOG2 bits wide.
- On the tick where `cnt` wraps to 0, the sample is `(acc + audio_in) >> DECIM_LOG2`. The low bits are truncated.
- On that same tick the accumulator restarts at 0.
- The 16-bit sample is converted to two's complement by inverting bit 15, so 0x8000 maps to 0x0000.
- The converted sample is pushed into the FIFO.

FIFO:
- 4 entries × 16 bits, with 2-bit read/write pointers that wrap modulo 4 and a 3-bit count.
- Push while full: the new sample is discarded, `overflow` is set, and FIFO contents are unchanged.
- Push and pop in the same cycle while full: both take effect and the count stays at 4. No overflow.
- Push and pop in the same cycle while empty: no pop occurs, the push is stored, and `underflow` is set.

Serializer:
- A divider counts `clk` cycles 0..BCLK_HALF-1. `i2s_bclk` toggles on each wrap.
- A 5-bit slot counter `b` advances on every falling edge of `i2s_bclk`, wrapping 31 to 0.
- `i2s_lrclk` equals `b[4]`.
- Entering slot 0 (word load):
  - If `mute` is high, the frame word becomes 0x0000 and the FIFO is still popped if non-empty.
  - Otherwise, if the FIFO is non-empty, pop into the frame word.
  - Otherwise, keep the previous word and set `underflow`.
- I2S one-bit delay: in slot `b`, `i2s_data` carries bit `15 - ((b-1) mod 16)` of the word for that half-frame.
  - Slot 0 carries the LSB of the previous frame's right channel.
  - Slots 1..16 carry MSB..LSB of the left channel.
  - Slots 17..31 carry MSB..bit 1 of the right channel.
- Left and right carry the same word.

Reset (asynchronous, `rst` high):
- Accumulator, `cnt`, FIFO pointers, count, divider and `b` are cleared to 0.
- The frame word is cleared to 0x0000.
- `i2s_bclk`, `i2s_lrclk`, `i2s_data`, `overflow` and `underflow` go to 0.
- Asserting `rst` mid-frame or mid-accumulation discards all partial state immediately.
- After `rst` deasserts, the first `i2s_bclk` rising edge occurs BCLK_HALF cycles later.
- The first load happens at the falling edge that wraps `b` from 31 to 0, which is 32 bit periods after release.

## Timing
- Decimated sample enters the FIFO (count increments) 1 `clk` after the 2^DECIM_LOG2-th `cpu_clk_en`.
- FIFO pop and word load happen in the same `clk` as the `i2s_bclk` falling edge that enters slot 0.
- `i2s_data` and `i2s_lrclk` change only in the cycle `i2s_bclk` falls. They are stable across every rising edge.
- Bit period is 2·BCLK_HALF `clk` cycles. Frame period is 64·BCLK_HALF cycles.
- Worst-case latency from a sample leaving the decimator to its MSB on the wire is (FIFO occupancy + 1) frames + 1 bit period.
- `overflow` and `underflow` rise 1 `clk` after the causing event. They clear only on `rst`.
- `mute` is sampled only at word load. Changing it mid-frame does not alter the frame in flight.

## Test plan
- Reset mid-frame:
  - Stimulus: assert `rst` during slot 20.
  - Required: all outputs read 0 within the same cycle; FIFO reads empty.
  - After release: no `i2s_bclk` edge for BCLK_HALF cycles.
- Constant input, `DECIM_LOG2`=5:
  - Stimulus: `audio_in`=0xC000 with `cpu_clk_en` every cycle.
  - Required: FIFO receives 0x4000 after 32 ticks.
  - Required: the next frame shows lrclk=0, slot 1 data=0 (MSB), slot 2 data=1, then zeros.
- Averaging:
  - Stimulus: alternate `audio_in` 0x0000/0x0002 over 32 ticks.
  - Required: pushed sample is 0x8001. Checks the truncation rule.
- Overflow:
  - Stimulus: hold `i2s_bclk` frames off with a large BCLK_HALF and push 5 samples.
  - Required: `overflow`=1 after the 5th push; FIFO count is 4; the first 4 samples are serialized in order.
- Underflow and repeat:
  - Stimulus: stop `cpu_clk_en` after one sample.
  - Required: that sample is sent once, `underflow`=1 at the next slot-0 load, and the same word is retransmitted.
- Mute:
  - Stimulus: `mute`=1 set in slot 10 with the FIFO holding 0x7FFF.
  - Required: the current frame is unchanged; the next frame is all zeros and the FIFO count decrements.
